// File: rtl/mix_columns_if.sv
// State bus for the MixColumns stage: producer drives state_in/in_valid, the stage returns state_out/out_valid.
// With INV_MIX_COLUMNS_EN defined the bus also carries inv_mode alongside state_in.
interface mix_columns_if;
   logic [127:0] state_in;
   logic         in_valid;
   logic [127:0] state_out;
   logic         out_valid;
`ifdef INV_MIX_COLUMNS_EN
   logic         inv_mode;
`endif

   modport master (
      output state_in,
      output in_valid,
`ifdef INV_MIX_COLUMNS_EN
      output inv_mode,
`endif
      input  state_out,
      input  out_valid
   );

   modport slave (
      input  state_in,
      input  in_valid,
`ifdef INV_MIX_COLUMNS_EN
      input  inv_mode,
`endif
      output state_out,
      output out_valid
   );
endinterface

// File: rtl/mix_columns.sv
// AES-128 MixColumns layer, four columns in parallel, one registered output stage.
// Define INV_MIX_COLUMNS_EN to add inv_mode and the InvMixColumns datapath.
module mix_columns (
   input logic          clk,
   input logic          rst,
   mix_columns_if.slave bus
);

   logic [127:0] stateOut_q, stateOut_d;
   logic         outValid_q, outValid_d;
   logic [127:0] result;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [127:0] mixForward(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   s0, s1, s2, s3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         s0 = s[8*(15-4*c) +: 8];
         s1 = s[8*(14-4*c) +: 8];
         s2 = s[8*(13-4*c) +: 8];
         s3 = s[8*(12-4*c) +: 8];
         r[8*(15-4*c) +: 8] = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
         r[8*(14-4*c) +: 8] = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
         r[8*(13-4*c) +: 8] = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
         r[8*(12-4*c) +: 8] = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
      end
      return r;
   endfunction

`ifdef INV_MIX_COLUMNS_EN
   // Each byte's x2/x4/x8 multiples are formed once and combined into 09/0B/0D/0E.
   function automatic logic [127:0] mixInverse(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   x1 [4];
      logic [7:0]   x2 [4];
      logic [7:0]   x4 [4];
      logic [7:0]   x8 [4];
      logic [7:0]   m9 [4];
      logic [7:0]   mB [4];
      logic [7:0]   mD [4];
      logic [7:0]   mE [4];
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) begin
            x1[k] = s[8*(15-4*c-k) +: 8];
            x2[k] = xtime(x1[k]);
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
            m9[k] = x8[k] ^ x1[k];
            mB[k] = x8[k] ^ x2[k] ^ x1[k];
            mD[k] = x8[k] ^ x4[k] ^ x1[k];
            mE[k] = x8[k] ^ x4[k] ^ x2[k];
         end
         r[8*(15-4*c) +: 8] = mE[0] ^ mB[1] ^ mD[2] ^ m9[3];
         r[8*(14-4*c) +: 8] = m9[0] ^ mE[1] ^ mB[2] ^ mD[3];
         r[8*(13-4*c) +: 8] = mD[0] ^ m9[1] ^ mE[2] ^ mB[3];
         r[8*(12-4*c) +: 8] = mB[0] ^ mD[1] ^ m9[2] ^ mE[3];
      end
      return r;
   endfunction
`endif

   // The transform result is only captured when in_valid is set, so junk on an idle bus never reaches the register.
   always_comb begin
      result = mixForward(bus.state_in);
`ifdef INV_MIX_COLUMNS_EN
      if (bus.inv_mode) begin
         result = mixInverse(bus.state_in);
      end
`endif
      stateOut_d = stateOut_q;
      outValid_d = bus.in_valid;
      if (bus.in_valid) begin
         stateOut_d = result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateOut_q <= '0;
         outValid_q <= 1'b0;
      end else begin
         stateOut_q <= stateOut_d;
         outValid_q <= outValid_d;
      end
   end

   assign bus.state_out = stateOut_q;
   assign bus.out_valid = outValid_q;

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: GF(2^8) matrix reference model plus FIPS-197 literal vectors.
// Exercises the inverse path too when INV_MIX_COLUMNS_EN is defined.
module tb_mix_columns;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [127:0] expOut;
   logic         expValid;

   mix_columns_if bus ();

   mix_columns dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Generic shift-and-add GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      logic       hi;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         hi = aa[7];
         aa = {aa[6:0], 1'b0};
         if (hi) aa = aa ^ 8'h1B;
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   // Circulant matrix product: row r weights input byte k by base[(k - r) mod 4].
   function automatic logic [127:0] refMix(input logic [127:0] s, input bit inv);
      logic [7:0]   base [4];
      logic [127:0] r;
      logic [7:0]   acc;
      if (inv) base = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
      else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) begin
               acc = acc ^ gmul(base[(k - row + 4) % 4], s[8*(15-4*c-k) +: 8]);
            end
            r[8*(15-4*c-row) +: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic bit curInv();
`ifdef INV_MIX_COLUMNS_EN
      return bus.inv_mode;
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         expOut   <= '0;
         expValid <= 1'b0;
      end else begin
         expValid <= bus.in_valid;
         if (bus.in_valid) expOut <= refMix(bus.state_in, curInv());
      end
   end

   always @(negedge clk) begin
      checks++;
      if (bus.state_out !== expOut || bus.out_valid !== expValid) begin
         errors++;
         $display("[TB] FAIL model_compare t=%0t state_out=%h out_valid=%b required %h %b",
                  $time, bus.state_out, bus.out_valid, expOut, expValid);
      end
   end

   task automatic applyStimulus(input logic valid, input logic [127:0] data, input bit inv);
      bus.in_valid = valid;
      bus.state_in = data;
`ifdef INV_MIX_COLUMNS_EN
      bus.inv_mode = inv;
`else
      if (inv) $display("[TB] inverse request ignored in forward-only build");
`endif
   endtask

   task automatic checkOutput(input string name, input logic [127:0] wantOut, input logic wantValid);
      checks++;
      if (bus.state_out !== wantOut || bus.out_valid !== wantValid) begin
         errors++;
         $display("[TB] FAIL %s state_out=%h out_valid=%b required %h %b",
                  name, bus.state_out, bus.out_valid, wantOut, wantValid);
      end
   endtask

   initial begin
      logic [127:0] rnd;
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      repeat (2) @(negedge clk);
      checkOutput("reset_state", 128'h0, 1'b0);
      #1 rst = 1'b0;

      applyStimulus(1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0);
      @(negedge clk);
      checkOutput("fips_round1", 128'h046681e5e0cb199a48f8d37a2806264c, 1'b1);

      #1 applyStimulus(1'b1, 128'hdb135345f20a225c01010101c6c6c6c6, 1'b0);
      @(negedge clk);
      checkOutput("known_cols_a", 128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b1);
      #1 applyStimulus(1'b1, 128'hd4d4d4d52d26314c0000000001010101, 1'b0);
      @(negedge clk);
      checkOutput("known_cols_b", 128'hd5d5d7d64d7ebdf80000000001010101, 1'b1);

      #1 applyStimulus(1'b0, 128'h627a6f6644b109c82b18330a81c3b3e5, 1'b0);
      @(negedge clk);
      checkOutput("hold", 128'hd5d5d7d64d7ebdf80000000001010101, 1'b0);

      #1 applyStimulus(1'b1, 128'h627a6f6644b109c82b18330a81c3b3e5, 1'b0);
      #1 rst = 1'b1;
      #1 checkOutput("async_reset", 128'h0, 1'b0);
      #1 applyStimulus(1'b0, '0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_discard", 128'h0, 1'b0);
      #1 applyStimulus(1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0);
      @(negedge clk);
      checkOutput("after_reset", 128'h046681e5e0cb199a48f8d37a2806264c, 1'b1);

`ifdef INV_MIX_COLUMNS_EN
      #1 applyStimulus(1'b1, 128'h046681e5e0cb199a48f8d37a2806264c, 1'b1);
      @(negedge clk);
      checkOutput("inverse_fips", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1);
`endif

      for (int i = 0; i < 400; i++) begin
         #1;
         rnd = {$urandom, $urandom, $urandom, $urandom};
         applyStimulus(1'($urandom_range(0, 3) != 0), rnd, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 39) == 0) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
         @(negedge clk);
      end

      #1 applyStimulus(1'b0, '0, 1'b0);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
